// File: rtl/alu32_share_arbiter.sv
// Round-robin arbiter that lets two requesters take turns on one external combinational ALU.
// Each op takes an accept cycle, an execute cycle and a response cycle.
module alu32_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,

  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [OPW-1:0]   i_req0_op,
  input  logic             i_req0_cin,

  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [OPW-1:0]   i_req1_op,
  input  logic             i_req1_cin,

  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_result,
  output logic             o_rsp0_cout,

  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_result,
  output logic             o_rsp1_cout,

  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [OPW-1:0]   o_alu_op,
  output logic             o_alu_cin,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prio;
  logic             r_gnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic             r_alu_cin;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_sel;
  logic             w_accept;
  logic             w_rsp_take;
  logic             w_req0_ready;
  logic             w_req1_ready;

  // With both ports valid the priority bit breaks the tie; otherwise the lone valid port wins.
  always_comb begin
    w_sel        = 1'b0;
    w_accept     = 1'b0;
    w_rsp_take   = 1'b0;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_next       = r_state;

    if (i_req0_valid && i_req1_valid) begin
      w_sel = r_prio;
    end else begin
      w_sel = i_req1_valid;
    end

    case (r_state)
      S_IDLE: begin
        w_req0_ready = i_req0_valid && !w_sel;
        w_req1_ready = i_req1_valid && w_sel;
        w_accept     = i_req0_valid || i_req1_valid;
        if (w_accept) begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_take = r_gnt ? i_rsp1_ready : i_rsp0_ready;
        if (w_rsp_take) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operands stay on the ALU after the op finishes; only reset clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio    <= 1'b0;
      r_gnt     <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_alu_cin <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt     <= w_sel;
        r_alu_a   <= w_sel ? i_req1_a   : i_req0_a;
        r_alu_b   <= w_sel ? i_req1_b   : i_req0_b;
        r_alu_op  <= w_sel ? i_req1_op  : i_req0_op;
        r_alu_cin <= w_sel ? i_req1_cin : i_req0_cin;
      end
      if (r_state == S_EXEC) begin
        r_result <= i_alu_result;
        r_cout   <= i_alu_cout;
      end
      if (w_rsp_take) begin
        r_prio <= ~r_gnt;
      end
    end
  end

  assign o_req0_ready  = w_req0_ready;
  assign o_req1_ready  = w_req1_ready;
  assign o_rsp0_valid  = (r_state == S_RESP) && !r_gnt;
  assign o_rsp1_valid  = (r_state == S_RESP) && r_gnt;
  assign o_rsp0_result = r_result;
  assign o_rsp1_result = r_result;
  assign o_rsp0_cout   = r_cout;
  assign o_rsp1_cout   = r_cout;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;
  assign o_alu_cin     = r_alu_cin;

  // Handshake invariants: at most one grant, and grants only while idle.
  assert property (@(posedge i_clk) disable iff (i_rst) !(o_req0_ready && o_req1_ready));
  assert property (@(posedge i_clk) disable iff (i_rst)
                   (o_req0_ready || o_req1_ready) |-> (r_state == S_IDLE));

endmodule

// File: tb/tb_alu32_share_arbiter.sv
// Directed bench for alu32_share_arbiter with a small behavioural ALU hung off the alu_* ports.
// Expected results are hand-computed constants per vector.
module tb_alu32_share_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0Valid, req1Valid, req0Ready, req1Ready;
  logic [31:0] req0A, req0B, req1A, req1B;
  logic [2:0]  req0Op, req1Op;
  logic        req0Cin, req1Cin;
  logic        rsp0Valid, rsp1Valid, rsp0Ready, rsp1Ready;
  logic [31:0] rsp0Result, rsp1Result;
  logic        rsp0Cout, rsp1Cout;
  logic [31:0] aluA, aluB, aluResult;
  logic [2:0]  aluOp;
  logic        aluCin, aluCout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // SUB reports borrow on the carry-out; logic ops never carry.
  function automatic logic [32:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op, input logic cin);
    case (op)
      OP_ADD:  aluModel = {1'b0, a} + {1'b0, b} + {32'b0, cin};
      OP_SUB:  aluModel = {1'b0, a} - {1'b0, b} - {32'b0, cin};
      OP_AND:  aluModel = {1'b0, a & b};
      OP_OR:   aluModel = {1'b0, a | b};
      OP_XOR:  aluModel = {1'b0, a ^ b};
      default: aluModel = '0;
    endcase
  endfunction

  assign {aluCout, aluResult} = aluModel(aluA, aluB, aluOp, aluCin);

  alu32_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0Valid), .o_req0_ready(req0Ready), .i_req0_a(req0A), .i_req0_b(req0B),
    .i_req0_op(req0Op), .i_req0_cin(req0Cin),
    .i_req1_valid(req1Valid), .o_req1_ready(req1Ready), .i_req1_a(req1A), .i_req1_b(req1B),
    .i_req1_op(req1Op), .i_req1_cin(req1Cin),
    .o_rsp0_valid(rsp0Valid), .i_rsp0_ready(rsp0Ready), .o_rsp0_result(rsp0Result),
    .o_rsp0_cout(rsp0Cout),
    .o_rsp1_valid(rsp1Valid), .i_rsp1_ready(rsp1Ready), .o_rsp1_result(rsp1Result),
    .o_rsp1_cout(rsp1Cout),
    .o_alu_a(aluA), .o_alu_b(aluB), .o_alu_op(aluOp), .o_alu_cin(aluCin),
    .i_alu_result(aluResult), .i_alu_cout(aluCout)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic readyOf(input int port);
    return (port == 0) ? req0Ready : req1Ready;
  endfunction

  task automatic applyStimulus(input int port, input logic valid, input logic [31:0] a,
                               input logic [31:0] b, input logic [2:0] op, input logic cin);
    if (port == 0) begin
      req0Valid = valid; req0A = a; req0B = b; req0Op = op; req0Cin = cin;
    end else begin
      req1Valid = valid; req1A = a; req1B = b; req1Op = op; req1Cin = cin;
    end
  endtask

  task automatic setRspReady(input int port, input logic value);
    if (port == 0) rsp0Ready = value;
    else           rsp1Ready = value;
  endtask

  task automatic waitReady(input int port, input string tag);
    int n = 0;
    #1;
    while (readyOf(port) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_ready"}, 64'(readyOf(port)), 64'd1);
    checkOutput({tag, "_otherReady"}, 64'(readyOf(1 - port)), 64'd0);
  endtask

  task automatic checkResponse(input int port, input logic [31:0] expRes,
                               input logic expCout, input string tag);
    logic [1:0] expValid;
    expValid = (port == 0) ? 2'b10 : 2'b01;
    checkOutput({tag, "_rspValid"}, 64'({rsp0Valid, rsp1Valid}), 64'(expValid));
    checkOutput({tag, "_result"}, 64'((port == 0) ? rsp0Result : rsp1Result), 64'(expRes));
    checkOutput({tag, "_cout"}, 64'((port == 0) ? rsp0Cout : rsp1Cout), 64'(expCout));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, 64'({req0Ready, req1Ready, rsp0Valid, rsp1Valid}), 64'd0);
    checkOutput({tag, "_results"}, {rsp0Result, rsp1Result}, 64'd0);
    checkOutput({tag, "_couts"}, 64'({rsp0Cout, rsp1Cout}), 64'd0);
    checkOutput({tag, "_aluAB"}, {aluA, aluB}, 64'd0);
    checkOutput({tag, "_aluOpCin"}, 64'({aluOp, aluCin}), 64'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic runOp(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic cin, input logic [31:0] expRes,
                       input logic expCout, input string tag);
    applyStimulus(port, 1'b1, a, b, op, cin);
    waitReady(port, tag);
    tick();
    applyStimulus(port, 1'b0, a, b, op, cin);
    #1;
    checkOutput({tag, "_execValid"}, 64'({rsp0Valid, rsp1Valid}), 64'd0);
    checkOutput({tag, "_aluOperands"}, {aluA, aluB}, {a, b});
    tick();
    checkResponse(port, expRes, expCout, tag);
    setRspReady(port, 1'b1);
    tick();
    setRspReady(port, 1'b0);
    #1;
    checkOutput({tag, "_doneValid"}, 64'({rsp0Valid, rsp1Valid}), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (req0Ready & req1Ready) !== 1'b0)
      checkOutput("readyExclusive", 64'(req0Ready & req1Ready), 64'd0);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n0;
    int n1;
    rst = 1'b1;
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    rsp0Ready = 1'b0;
    rsp1Ready = 1'b0;

    doReset();
    checkAllZero("reset");

    $display("[TB] single ops");
    runOp(0, 32'd5, 32'd3, OP_ADD, 1'b0, 32'd8, 1'b0, "add5p3");
    runOp(1, 32'hFFFF_FFFF, 32'd1, OP_ADD, 1'b0, 32'd0, 1'b1, "addWrap");
    runOp(1, 32'h7FFF_FFFF, 32'd0, OP_ADD, 1'b1, 32'h8000_0000, 1'b0, "addCin");
    runOp(0, 32'h1234_5678, 32'hFFFF_0000, OP_XOR, 1'b0, 32'hEDCB_5678, 1'b0, "xor");
    runOp(1, 32'd3, 32'd5, OP_SUB, 1'b0, 32'hFFFF_FFFE, 1'b1, "subBorrow");
    runOp(0, 32'hF0F0_0000, 32'h0F0F_00FF, OP_OR, 1'b0, 32'hFFFF_00FF, 1'b0, "or");

    // Port 0 requests a = 100+k, b = 1 (ADD); port 1 requests a = 200+k, b = 50 (SUB).
    $display("[TB] alternation");
    doReset();
    n0 = 0;
    n1 = 0;
    applyStimulus(0, 1'b1, 32'd100, 32'd1, OP_ADD, 1'b0);
    applyStimulus(1, 1'b1, 32'd200, 32'd50, OP_SUB, 1'b0);
    for (int i = 0; i < 8; i++) begin
      int port;
      logic [31:0] expRes;
      port = i % 2;
      expRes = (port == 0) ? 32'(101 + n0) : 32'(150 + n1);
      waitReady(port, $sformatf("alt%0d", i));
      tick();
      if (port == 0) begin
        n0++;
        applyStimulus(0, 1'b1, 32'(100 + n0), 32'd1, OP_ADD, 1'b0);
      end else begin
        n1++;
        applyStimulus(1, 1'b1, 32'(200 + n1), 32'd50, OP_SUB, 1'b0);
      end
      tick();
      checkResponse(port, expRes, 1'b0, $sformatf("alt%0d", i));
      setRspReady(port, 1'b1);
      tick();
      setRspReady(port, 1'b0);
    end
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    #1;

    $display("[TB] backpressure");
    applyStimulus(0, 1'b1, 32'd7, 32'd2, OP_SUB, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_0F0F, 32'h0000_00FF, OP_AND, 1'b0);
    waitReady(0, "bpReq0");
    tick();
    applyStimulus(0, 1'b0, 32'd7, 32'd2, OP_SUB, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      checkResponse(0, 32'd5, 1'b0, $sformatf("bpHold%0d", i));
      checkOutput($sformatf("bpReq1Blocked%0d", i), 64'(req1Ready), 64'd0);
      tick();
    end
    setRspReady(0, 1'b1);
    tick();
    setRspReady(0, 1'b0);
    #1;
    checkOutput("bpReq1Accept", 64'(req1Ready), 64'd1);
    tick();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    tick();
    checkResponse(1, 32'h0000_000F, 1'b0, "bpReq1");
    setRspReady(1, 1'b1);
    tick();
    setRspReady(1, 1'b0);
    #1;

    $display("[TB] reset mid-transaction");
    runOp(0, 32'd9, 32'd4, OP_ADD, 1'b1, 32'd14, 1'b0, "preRst");
    applyStimulus(1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, OP_OR, 1'b0);
    waitReady(1, "rstExec");
    tick();
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkAllZero("rstExec");
    applyStimulus(0, 1'b1, 32'd1, 32'd1, OP_ADD, 1'b0);
    applyStimulus(1, 1'b1, 32'd2, 32'd2, OP_ADD, 1'b0);
    #1;
    checkOutput("rstExecPrio", 64'({req0Ready, req1Ready}), 64'b10);
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    #1;
    checkOutput("rstExecSoleReq1", 64'({req0Ready, req1Ready}), 64'b01);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rstExecQuiet%0d", i), 64'({rsp0Valid, rsp1Valid}), 64'd0);
    end

    applyStimulus(0, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, OP_XOR, 1'b0);
    waitReady(0, "rstResp");
    tick();
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    tick();
    checkResponse(0, 32'hFFFF_FFFF, 1'b0, "rstRespPre");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkAllZero("rstResp");
    applyStimulus(0, 1'b1, 32'd1, 32'd1, OP_ADD, 1'b0);
    applyStimulus(1, 1'b1, 32'd2, 32'd2, OP_ADD, 1'b0);
    #1;
    checkOutput("rstRespPrio", 64'({req0Ready, req1Ready}), 64'b10);
    applyStimulus(0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rstRespQuiet%0d", i), 64'({rsp0Valid, rsp1Valid}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
